// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave, all CPOL/CPHA modes, sclk domain only; define SPI_SLAVE_TRISTATE_EN to float miso when deselected
module spi_slave_if #(
  parameter int NBITS = 8
) (
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic [NBITS-1:0] tx_data,
  output logic [NBITS-1:0] rx_data,
  output logic             rx_toggle,
  output logic             tx_toggle,
  output logic             short_frame
);
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  logic             sclk_i, clr, sampled, mid, tx_bit;
  logic [CW-1:0]    in_cnt, out_cnt, k;
  logic [NBITS-1:0] rx_sh, tx_sh, rx_next;
  assign sclk_i  = sclk ^ cpol ^ cpha;
  assign clr     = reset | cs_n;
  assign rx_next = lsb_first ? {mosi, rx_sh[NBITS-1:1]} : {rx_sh[NBITS-2:0], mosi};
  assign k       = lsb_first ? out_cnt : LAST - out_cnt;
  // the first bit of a byte comes straight from tx_data, before it is latched
  assign tx_bit  = (out_cnt == '0 && in_cnt == '0) ? tx_data[k] : tx_sh[k];
`ifdef SPI_SLAVE_TRISTATE_EN
  assign miso = clr ? 1'bz : tx_bit;
`else
  assign miso = !clr && tx_bit;
`endif
  always_ff @(posedge sclk_i or posedge clr)
    if (clr) begin
      in_cnt  <= '0;
      sampled <= 1'b0;
    end else begin
      in_cnt  <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
      sampled <= 1'b1;
    end
  always_ff @(negedge sclk_i or posedge clr)
    if (clr) out_cnt <= '0;
    else if (sampled) out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;
  // mid mirrors in_cnt != 0 but survives the cs_n clear, so the cs_n edge can see it
  always_ff @(posedge sclk_i or posedge reset)
    if (reset) begin
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_data   <= '0;
      rx_toggle <= 1'b0;
      tx_toggle <= 1'b0;
      mid       <= 1'b0;
    end else if (!cs_n) begin
      rx_sh <= rx_next;
      mid   <= in_cnt != LAST;
      if (in_cnt == '0) begin
        tx_sh     <= tx_data;
        tx_toggle <= ~tx_toggle;
      end
      if (in_cnt == LAST) begin
        rx_data   <= rx_next;
        rx_toggle <= ~rx_toggle;
      end
    end
  always_ff @(posedge cs_n or posedge reset)
    if (reset) short_frame <= 1'b0;
    else if (mid) short_frame <= 1'b1;
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: bit-banged SPI master with a queue scoreboard on rx_data
module tb_spi_slave_if;
  localparam int H = 10;
  logic       reset = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, rx_toggle, tx_toggle, short_frame;
  logic [7:0] rx_data;
  logic [7:0] exp_rx[$];
  int         n_chk = 0, n_fail = 0, rx_flips = 0, tx_flips = 0;

  spi_slave_if #(.NBITS(8)) dut (
    .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .tx_data(tx_data),
    .rx_data(rx_data), .rx_toggle(rx_toggle), .tx_toggle(tx_toggle),
    .short_frame(short_frame)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #5;
    forever begin
      @(rx_toggle);
      if (!reset) begin
        #1;
        rx_flips++;
        if (exp_rx.size() == 0) chk("rx_unexpected", rx_data, 8'hxx);
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  initial begin
    #5;
    forever begin
      @(tx_toggle);
      if (!reset) tx_flips++;
    end
  end

  task automatic set_mode(input logic p, input logic h, input logic l);
    cpol = p; cpha = h; lsb_first = l; sclk = p;
    #H;
  endtask

  task automatic xfer(input int nb, input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] seq);
    mi = '0; seq = '0;
    for (int i = 0; i < nb; i++) begin
      int j = lsb_first ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[j]; #H;
        mi[j] = miso; seq[7-i] = miso;
        sclk = ~sclk; #H; sclk = ~sclk;
      end else begin
        sclk = ~sclk; mosi = mo[j]; #H;
        mi[j] = miso; seq[7-i] = miso;
        sclk = ~sclk; #H;
      end
    end
  endtask

  task automatic frame(input logic [7:0] mo, input logic [7:0] so, output logic [7:0] seq);
    logic [7:0] mi;
    int r0 = rx_flips, t0 = tx_flips;
    tx_data = so;
    exp_rx.push_back(mo);
    cs_n = 1'b0; #H;
    xfer(8, mo, mi, seq);
    chk("master_rx", mi, so);
    #H; cs_n = 1'b1; #H;
    chk("rx_flips", 8'(rx_flips - r0), 8'd1);
    chk("tx_flips", 8'(tx_flips - t0), 8'd1);
  endtask

  initial begin
    logic [7:0] seq, mi;
    logic [7:0] pm[3] = '{8'h3C, 8'hF9, 8'h21};
    logic [7:0] ps[3] = '{8'hE9, 8'hDB, 8'h48};
    int r0, t0;
    #H;
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_toggle", rx_toggle, 1'b0);
    chk("rst_tx_toggle", tx_toggle, 1'b0);
    chk("rst_short", short_frame, 1'b0);
`ifdef SPI_SLAVE_TRISTATE_EN
    chk("rst_miso", miso, 1'bz);
`else
    chk("rst_miso", miso, 1'b0);
`endif
    #H; reset = 1'b0; #H;
    set_mode(0, 0, 0);
    frame(8'hA5, 8'h7B, seq);
    chk("seq_msb", seq, 8'h7B);
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 0);
      for (int p = 0; p < 3; p++) frame(pm[p], ps[p], seq);
    end
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 1);
      for (int p = 0; p < 3; p++) frame(pm[p], ps[p], seq);
    end
    set_mode(0, 0, 1);
    frame(8'hA5, 8'h7B, seq);
    chk("seq_lsb", seq, 8'hDE);
    chk("short_clear", short_frame, 1'b0);
    // two bytes under one cs_n, second tx byte loaded on the first tx_toggle flip
    set_mode(0, 0, 0);
    r0 = rx_flips; t0 = tx_flips;
    tx_data = 8'hAA;
    exp_rx.push_back(8'h11);
    exp_rx.push_back(8'h22);
    fork begin @(tx_toggle); #5 tx_data = 8'h55; end join_none
    cs_n = 1'b0; #H;
    xfer(8, 8'h11, mi, seq);
    chk("multi_rx0", mi, 8'hAA);
    xfer(8, 8'h22, mi, seq);
    chk("multi_rx1", mi, 8'h55);
    #H; cs_n = 1'b1; #H;
    chk("multi_rx_flips", 8'(rx_flips - r0), 8'd2);
    chk("multi_tx_flips", 8'(tx_flips - t0), 8'd2);
    chk("multi_rx_last", rx_data, 8'h22);
    cs_n = 1'b0; #H;
    xfer(3, 8'hFF, mi, seq);
    #H; cs_n = 1'b1; #H;
    chk("short_set", short_frame, 1'b1);
    chk("short_rx_kept", rx_data, 8'h22);
    frame(8'h5A, 8'hC3, seq);
    chk("short_sticky", short_frame, 1'b1);
    chk("after_short_rx", rx_data, 8'h5A);
    cs_n = 1'b0; #H;
    xfer(3, 8'h0F, mi, seq);
    reset = 1'b1; #1;
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_rx_toggle", rx_toggle, 1'b0);
    chk("mid_rst_tx_toggle", tx_toggle, 1'b0);
    chk("mid_rst_short", short_frame, 1'b0);
`ifdef SPI_SLAVE_TRISTATE_EN
    chk("mid_rst_miso", miso, 1'bz);
`else
    chk("mid_rst_miso", miso, 1'b0);
`endif
    #H; cs_n = 1'b1; reset = 1'b0; #(4*H);
    chk("rx_queue_empty", 8'(exp_rx.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
